// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32_pipelined_risc core: opcode values,
// instruction classes, the bubble (NOP) instruction word and the packed
// pipeline-register layouts passed between IF, ID, EX, MEM and WB.
package mips32_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b000100;
  localparam logic [5:0] OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011;
  localparam logic [5:0] OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ = 6'b001110;
  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};

  typedef enum logic [2:0] {
    NOP,
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT
  } instr_class_e;

  function automatic instr_class_e decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic [5:0]   op;
    logic [31:0]  npc;
    instr_class_e cls;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dst;
    logic         we;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  imm;
  } id_ex_t;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   dst;
    logic         we;
    logic [31:0]  result;
    logic [31:0]  b;
  } ex_mem_t;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   dst;
    logic         we;
    logic [31:0]  result;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{ir: NOP_WORD, npc: '0};

  localparam id_ex_t ID_EX_NOP = '{op: OP_NOP, npc: '0, cls: NOP, rs: '0,
                                   rt: '0, dst: '0, we: 1'b0, a: '0, b: '0,
                                   imm: '0};

  localparam ex_mem_t EX_MEM_NOP = '{cls: NOP, dst: '0, we: 1'b0,
                                     result: '0, b: '0};

  localparam mem_wb_t MEM_WB_NOP = '{cls: NOP, dst: '0, we: 1'b0,
                                     result: '0};

endpackage

// File: rtl/mips32_pipelined_risc.sv
// Five-stage in-order 32-bit RISC core with a unified word-addressed
// memory. Reg, Mem, PC, HALTED and TAKEN_BRANCH live directly in this module
// so benches can preload and inspect them hierarchically.
// Ports:
//   clk1   - system clock, rising edge
//   rst_n  - asynchronous active-low reset (pipeline/flags only)
//   halted - mirrors HALTED
module mips32_pipelined_risc
  import mips32_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned PC_W      = 32
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [31:0]     Reg [0:31];
  logic [31:0]     Mem [0:MEM_DEPTH-1];
  logic [PC_W-1:0] PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;

  logic [PC_W-1:0] pc_d;
  logic            halted_d;
  logic            taken_branch_d;

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  assign halted = HALTED;

  // ---------------- ID: decode and register read ----------------
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_rd, id_dst;
  logic [31:0]     id_imm, id_a, id_b;
  instr_class_e    id_cls;
  logic            id_reads_rs, id_reads_rt, id_we;
  logic            wb_we;
  id_ex_t          id_ex_dec;

  assign wb_we = mem_wb_q.we && !HALTED;

  always_comb begin
    id_op  = if_id_q.ir[31:26];
    id_rs  = if_id_q.ir[25:21];
    id_rt  = if_id_q.ir[20:16];
    id_rd  = if_id_q.ir[15:11];
    id_imm = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
    id_cls = decode_class(id_op);

    id_reads_rs = (id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD) ||
                  (id_cls == STORE) || (id_cls == BRANCH);
    id_reads_rt = (id_cls == RR_ALU) || (id_cls == STORE);
    id_dst      = (id_cls == RR_ALU) ? id_rd : id_rt;
    id_we       = ((id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD)) &&
                  (id_dst != '0);

    // R0 reads as zero; a WB write in this same cycle is passed straight through.
    id_a = '0;
    if (id_rs != '0)
      id_a = (wb_we && (mem_wb_q.dst == id_rs)) ? mem_wb_q.result : Reg[id_rs];
    id_b = '0;
    if (id_rt != '0)
      id_b = (wb_we && (mem_wb_q.dst == id_rt)) ? mem_wb_q.result : Reg[id_rt];

    id_ex_dec = '{op: id_op, npc: if_id_q.npc, cls: id_cls, rs: id_rs, rt: id_rt,
                  dst: id_dst, we: id_we, a: id_a, b: id_b, imm: id_imm};
  end

  // ---------------- EX: forwarding, ALU, branch resolve ----------------
  logic [31:0]     ex_a, ex_b, ex_res;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;

  always_comb begin
    ex_a = id_ex_q.a;
    if (ex_mem_q.we && (ex_mem_q.dst == id_ex_q.rs))      ex_a = ex_mem_q.result;
    else if (mem_wb_q.we && (mem_wb_q.dst == id_ex_q.rs)) ex_a = mem_wb_q.result;

    ex_b = id_ex_q.b;
    if (ex_mem_q.we && (ex_mem_q.dst == id_ex_q.rt))      ex_b = ex_mem_q.result;
    else if (mem_wb_q.we && (mem_wb_q.dst == id_ex_q.rt)) ex_b = mem_wb_q.result;

    ex_res = '0;
    case (id_ex_q.op)
      OP_ADD:       ex_res = ex_a + ex_b;
      OP_SUB:       ex_res = ex_a - ex_b;
      OP_AND:       ex_res = ex_a & ex_b;
      OP_OR:        ex_res = ex_a | ex_b;
      OP_SLT:       ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:       ex_res = ex_a * ex_b;
      OP_ADDI:      ex_res = ex_a + id_ex_q.imm;
      OP_SUBI:      ex_res = ex_a - id_ex_q.imm;
      OP_SLTI:      ex_res = {31'd0, $signed(ex_a) < $signed(id_ex_q.imm)};
      OP_LW, OP_SW: ex_res = ex_a + id_ex_q.imm;
      default:      ex_res = '0;
    endcase

    ex_taken  = (id_ex_q.cls == BRANCH) &&
                ((id_ex_q.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
    ex_target = PC_W'(id_ex_q.npc + id_ex_q.imm);

    ex_mem_d = '{cls: id_ex_q.cls, dst: id_ex_q.dst, we: id_ex_q.we,
                 result: ex_res, b: ex_b};
  end

  // ---------------- MEM ----------------
  logic [AW-1:0] mem_addr;

  always_comb begin
    mem_addr = ex_mem_q.result[AW-1:0];
    mem_wb_d = '{cls: ex_mem_q.cls, dst: ex_mem_q.dst, we: ex_mem_q.we,
                 result: (ex_mem_q.cls == LOAD) ? Mem[mem_addr] : ex_mem_q.result};
  end

  // ---------------- hazards, IF and next state ----------------
  logic            load_use;
  logic            halt_pending;
  logic [PC_W-1:0] pc_plus1;

  always_comb begin
    pc_plus1 = PC + PC_W'(1);

    load_use = (id_ex_q.cls == LOAD) && id_ex_q.we &&
               ((id_reads_rs && (id_rs == id_ex_q.dst)) ||
                (id_reads_rt && (id_rt == id_ex_q.dst)));

    // A HLT anywhere from ID to WB, or already retired, keeps fetch frozen.
    halt_pending = (id_cls == HALT) || (id_ex_q.cls == HALT) ||
                   (ex_mem_q.cls == HALT) || (mem_wb_q.cls == HALT) || HALTED;

    pc_d           = PC;
    if_id_d        = if_id_q;
    id_ex_d        = id_ex_dec;
    halted_d       = HALTED || (mem_wb_q.cls == HALT);
    taken_branch_d = ex_taken;

    // Flush outranks the halt freeze and the load-use stall.
    if (ex_taken) begin
      pc_d    = ex_target;
      if_id_d = IF_ID_NOP;
      id_ex_d = ID_EX_NOP;
    end else if (halt_pending) begin
      if_id_d = IF_ID_NOP;
    end else if (load_use) begin
      id_ex_d = ID_EX_NOP;
    end else begin
      pc_d    = pc_plus1;
      if_id_d = '{ir: Mem[PC[AW-1:0]], npc: 32'(pc_plus1)};
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_id_q      <= IF_ID_NOP;
      id_ex_q      <= ID_EX_NOP;
      ex_mem_q     <= EX_MEM_NOP;
      mem_wb_q     <= MEM_WB_NOP;
    end else begin
      PC           <= pc_d;
      HALTED       <= halted_d;
      TAKEN_BRANCH <= taken_branch_d;
      if_id_q      <= if_id_d;
      id_ex_q      <= id_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
    end
  end

  // Architectural storage is deliberately outside the reset domain.
  always_ff @(posedge clk1) begin
    if (wb_we)
      Reg[mem_wb_q.dst] <= mem_wb_q.result;
  end

  always_ff @(posedge clk1) begin
    if ((ex_mem_q.cls == STORE) && !HALTED)
      Mem[mem_addr] <= ex_mem_q.b;
  end

endmodule

// File: tb/tb_mips32_pipelined_risc.sv
module tb_mips32_pipelined_risc;

  localparam logic [31:0] W_HLT = 32'hFC00_0000;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  mips32_pipelined_risc #(.MEM_DEPTH(1024), .PC_W(32)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .halted(halted)
  );

  always #5 clk1 = ~clk1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cycles;
  int unsigned taken_pulses;

  logic [31:0] prog [0:63];
  int unsigned prog_len;

  // reference model state (ISA-level interpreter)
  logic [31:0] mm [0:1023];
  logic [31:0] mr [0:31];

  typedef struct {
    logic [5:0]  op;
    logic        rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [18];

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic emit(input logic [31:0] w);
    prog[prog_len] = w;
    prog_len++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Holds reset, then preloads program (HLT fill elsewhere) and Reg[k]=k.
  task automatic load_and_reset();
    rst_n = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.Mem[i] <= W_HLT;
    for (int i = 0; i < int'(prog_len); i++) dut.Mem[i] <= prog[i];
    for (int k = 0; k < 32; k++) dut.Reg[k] <= 32'(k);
  endtask

  // Called at a negedge with reset low; counts edges until halted.
  task automatic run_to_halt(input int unsigned budget);
    cycles = 0;
    taken_pulses = 0;
    rst_n = 1'b1;
    while (cycles < budget && !halted) begin
      @(posedge clk1);
      #1;
      cycles++;
      if (dut.TAKEN_BRANCH) taken_pulses++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic model_run();
    int unsigned pc;
    int unsigned steps;
    logic [31:0] w, a, b, imm, res;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    pc = 0;
    steps = 0;
    while (steps < 200) begin
      w   = mm[pc % 1024];
      op  = w[31:26];
      rs  = w[25:21];
      rt  = w[20:16];
      rd  = w[15:11];
      imm = {{16{w[15]}}, w[15:0]};
      a   = (rs == 0) ? 32'd0 : mr[rs];
      b   = (rt == 0) ? 32'd0 : mr[rt];
      steps++;
      if (op == 6'b111111) break;
      pc = pc + 1;
      case (op)
        6'b000000: res = a + b;
        6'b000001: res = a - b;
        6'b000010: res = a & b;
        6'b000011: res = a | b;
        6'b000100: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'b000101: res = a * b;
        default:   res = 32'd0;
      endcase
      case (op)
        6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101:
          if (rd != 0) mr[rd] = res;
        6'b001010: if (rt != 0) mr[rt] = a + imm;
        6'b001011: if (rt != 0) mr[rt] = a - imm;
        6'b001100: if (rt != 0) mr[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'b001000: if (rt != 0) mr[rt] = mm[(a + imm) % 1024];
        6'b001001: mm[(a + imm) % 1024] = b;
        6'b001101: if (a != 0) pc = pc + imm;
        6'b001110: if (a == 0) pc = pc + imm;
        default: ;
      endcase
    end
  endtask

  initial begin
    // ---------------- single-instruction ALU table ----------------
    vecs[0]  = '{6'b000000, 1'b0, 32'd5,         32'd7,         16'h0000, 32'd12};
    vecs[1]  = '{6'b000000, 1'b0, 32'hFFFF_FFFF, 32'd1,         16'h0000, 32'd0};
    vecs[2]  = '{6'b000001, 1'b0, 32'd3,         32'd5,         16'h0000, 32'hFFFF_FFFE};
    vecs[3]  = '{6'b000010, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 16'h0000, 32'h00F0_1200};
    vecs[4]  = '{6'b000011, 1'b0, 32'hF000_0000, 32'h0000_000F, 16'h0000, 32'hF000_000F};
    vecs[5]  = '{6'b000100, 1'b0, 32'hFFFF_FFFF, 32'd1,         16'h0000, 32'd1};
    vecs[6]  = '{6'b000100, 1'b0, 32'd1,         32'hFFFF_FFFF, 16'h0000, 32'd0};
    vecs[7]  = '{6'b000100, 1'b0, 32'd5,         32'd5,         16'h0000, 32'd0};
    vecs[8]  = '{6'b000101, 1'b0, 32'd7,         32'd6,         16'h0000, 32'd42};
    vecs[9]  = '{6'b000101, 1'b0, 32'h0001_0000, 32'h0001_0000, 16'h0000, 32'd0};
    vecs[10] = '{6'b000101, 1'b0, 32'hFFFF_FFFF, 32'd3,         16'h0000, 32'hFFFF_FFFD};
    vecs[11] = '{6'b001010, 1'b1, 32'd10,        32'd0,         16'hFFFF, 32'd9};
    vecs[12] = '{6'b001011, 1'b1, 32'd0,         32'd0,         16'h0001, 32'hFFFF_FFFF};
    vecs[13] = '{6'b001100, 1'b1, 32'hFFFF_FFFB, 32'd0,         16'hFFFC, 32'd1};
    vecs[14] = '{6'b001100, 1'b1, 32'd5,         32'd0,         16'hFFFC, 32'd0};
    vecs[15] = '{6'b001010, 1'b1, 32'h7FFF_FFFF, 32'd0,         16'h0001, 32'h8000_0000};
    vecs[16] = '{6'b000110, 1'b0, 32'd1,         32'd2,         16'h0000, 32'hDEAD_BEEF};
    vecs[17] = '{6'b001011, 1'b1, 32'd10,        32'd0,         16'h8000, 32'h0000_800A};

    for (int v = 0; v < 18; v++) begin
      prog_len = 0;
      emit(vecs[v].rm ? ri(vecs[v].op, 5'd3, 5'd1, vecs[v].imm)
                      : rr(vecs[v].op, 5'd3, 5'd1, 5'd2));
      emit(W_HLT);
      load_and_reset();
      dut.Reg[1] <= vecs[v].a;
      dut.Reg[2] <= vecs[v].b;
      dut.Reg[3] <= 32'hDEAD_BEEF;
      run_to_halt(30);
      check($sformatf("alu_vec%0d", v), dut.Reg[3], vecs[v].exp);
    end

    // ---------------- program with dummy ORs ----------------
    prog_len = 0;
    emit(32'h2801_000A); emit(32'h2802_0014); emit(32'h2803_0019);
    emit(rr(6'b000011, 5'd15, 5'd7, 5'd7)); emit(rr(6'b000011, 5'd15, 5'd7, 5'd7));
    emit(32'h0022_2000);
    emit(rr(6'b000011, 5'd15, 5'd7, 5'd7));
    emit(32'h0083_2800);
    emit(W_HLT);
    load_and_reset();
    run_to_halt(20);
    check("p1_R0", dut.Reg[0], 32'd0);
    check("p1_R1", dut.Reg[1], 32'd10);
    check("p1_R2", dut.Reg[2], 32'd20);
    check("p1_R3", dut.Reg[3], 32'd25);
    check("p1_R4", dut.Reg[4], 32'd30);
    check("p1_R5", dut.Reg[5], 32'd55);
    check("p1_cycles", cycles, 32'd13);

    // ---------------- same program, back-to-back dependencies ----------------
    prog_len = 0;
    emit(32'h2801_000A); emit(32'h2802_0014); emit(32'h2803_0019);
    emit(32'h0022_2000); emit(32'h0083_2800); emit(W_HLT);
    load_and_reset();
    run_to_halt(20);
    check("p2_R4", dut.Reg[4], 32'd30);
    check("p2_R5", dut.Reg[5], 32'd55);
    check("p2_cycles", cycles, 32'd10);

    // ---------------- load-use ----------------
    prog_len = 0;
    emit(ri(6'b001000, 5'd2, 5'd1, 16'd0));
    emit(ri(6'b001010, 5'd2, 5'd2, 16'd45));
    emit(ri(6'b001001, 5'd2, 5'd1, 16'd1));
    emit(W_HLT);
    load_and_reset();
    dut.Reg[1] <= 32'd120;
    dut.Mem[120] <= 32'd85;
    run_to_halt(30);
    check("lu_mem121", dut.Mem[121], 32'd130);
    check("lu_R2", dut.Reg[2], 32'd130);
    check("lu_cycles", cycles, 32'd9);

    // ---------------- BNEQZ loop ----------------
    prog_len = 0;
    emit(ri(6'b001010, 5'd10, 5'd0, 16'd3));
    emit(ri(6'b001010, 5'd11, 5'd0, 16'd0));
    emit(ri(6'b001010, 5'd12, 5'd0, 16'd0));
    emit(ri(6'b001010, 5'd13, 5'd0, 16'd0));
    emit(ri(6'b001010, 5'd11, 5'd11, 16'd1));
    emit(ri(6'b001011, 5'd10, 5'd10, 16'd1));
    emit(ri(6'b001101, 5'd0, 5'd10, 16'hFFFD));
    emit(ri(6'b001010, 5'd12, 5'd12, 16'd1));
    emit(ri(6'b001010, 5'd13, 5'd13, 16'd1));
    emit(W_HLT);
    load_and_reset();
    run_to_halt(60);
    check("loop_R10", dut.Reg[10], 32'd0);
    check("loop_body", dut.Reg[11], 32'd3);
    check("loop_after1", dut.Reg[12], 32'd1);
    check("loop_after2", dut.Reg[13], 32'd1);
    check("loop_pulses", taken_pulses, 32'd2);
    check("loop_cycles", cycles, 32'd24);

    // ---------------- R0 writes discarded ----------------
    prog_len = 0;
    emit(ri(6'b001010, 5'd0, 5'd0, 16'd5));
    emit(rr(6'b000000, 5'd1, 5'd0, 5'd0));
    emit(W_HLT);
    load_and_reset();
    run_to_halt(30);
    check("r0_R0", dut.Reg[0], 32'd0);
    check("r0_R1", dut.Reg[1], 32'd0);

    // ---------------- reset mid-program ----------------
    prog_len = 0;
    emit(32'h2801_000A); emit(32'h2802_0014); emit(32'h2803_0019);
    emit(32'h0022_2000); emit(32'h0083_2800); emit(W_HLT);
    load_and_reset();
    rst_n = 1'b1;
    repeat (7) @(posedge clk1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_PC", dut.PC, 32'd0);
    check("mid_halted", {31'd0, halted}, 32'd0);
    check("mid_R1", dut.Reg[1], 32'd10);
    check("mid_R2", dut.Reg[2], 32'd20);
    check("mid_R3", dut.Reg[3], 32'd25);
    check("mid_R4", dut.Reg[4], 32'd4);
    @(negedge clk1);
    run_to_halt(30);
    check("rerun_R4", dut.Reg[4], 32'd30);
    check("rerun_R5", dut.Reg[5], 32'd55);
    #1 rst_n = 1'b0;
    #1;
    check("rst_after_halt", {31'd0, halted}, 32'd0);
    check("rst_after_halt_PC", dut.PC, 32'd0);

    // ---------------- randomized programs vs ISA model ----------------
    for (int it = 0; it < 20; it++) begin
      int unsigned n;
      n = 12;
      for (int i = 0; i < 1024; i++) mm[i] = W_HLT;
      for (int i = 0; i < int'(n); i++) begin
        int unsigned sel;
        logic [5:0] op;
        logic [31:0] w;
        sel = $urandom_range(0, 15);
        if (sel <= 5) begin
          op = 6'($urandom_range(0, 5));
          w  = rr(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
        end else if (sel <= 8) begin
          op = 6'($urandom_range(10, 12));
          w  = ri(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  16'($urandom));
        end else if (sel <= 10) begin
          w = ri(6'b001000, 5'($urandom_range(0, 7)), 5'd0, 16'(200 + $urandom_range(0, 15)));
        end else if (sel <= 12) begin
          w = ri(6'b001001, 5'($urandom_range(0, 7)), 5'd0, 16'(200 + $urandom_range(0, 15)));
        end else if (sel <= 14 && i + 3 <= int'(n)) begin
          op = $urandom_range(0, 1) ? 6'b001101 : 6'b001110;
          w  = ri(op, 5'd0, 5'($urandom_range(0, 7)), 16'($urandom_range(1, 2)));
        end else begin
          w = {6'b010101, 26'($urandom)};
        end
        mm[i] = w;
      end
      for (int d = 200; d < 216; d++) mm[d] = $urandom;
      for (int k = 0; k < 32; k++) mr[k] = 32'(k);
      mr[0] = 32'h5A5A_5A5A;
      for (int k = 1; k < 8; k++)
        mr[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;

      prog_len = 0;
      load_and_reset();
      for (int i = 0; i < 1024; i++) dut.Mem[i] <= mm[i];
      for (int k = 0; k < 32; k++) dut.Reg[k] <= mr[k];
      model_run();
      run_to_halt(200);
      for (int k = 0; k < 8; k++)
        check($sformatf("rand%0d_R%0d", it, k), dut.Reg[k], mr[k]);
      for (int d = 200; d < 216; d++)
        check($sformatf("rand%0d_M%0d", it, d), dut.Mem[d], mm[d]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips32_pipelined_risc.md
Name: mips32_pipelined_risc

Overview:
- 32-bit, five-stage in-order RISC core: IF, ID, EX, MEM, WB.
- Unified word-addressed instruction/data memory held inside the block; no external bus.
- Top-level compute element; programs and register state are preloaded hierarchically by benches.
- Full forwarding, load-use interlock and branch flush, so dependent instructions need no software padding.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in unified memory (index = address[9:0]).
- PC_W, 32, program counter width; PC counts words and increments by 1.

Ports:
- clk1  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halted  out  1  mirrors internal HALTED register.

Behaviour:
- Hierarchically visible state, with these exact names:
  - Reg[0:31]: 32x32 register file.
  - Mem[0:MEM_DEPTH-1]: 32-bit unified memory.
  - PC, HALTED, TAKEN_BRANCH: 1-bit flags, except PC.
  - These must be plain regs, writable from a bench.
- Reset (async, rst_n=0): PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline registers hold a NOP (no write-enables). Reg and Mem contents are NOT touched by reset.
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
- RR-ALU instructions (rd = rs op rt):
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed, result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- RM-ALU instructions (rt = rs op imm): ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- Load/store:
  - LW 001000: rt = Mem[rs+imm].
  - SW 001001: Mem[rs+imm] = rt.
  - Address wraps modulo MEM_DEPTH.
- Branches:
  - BNEQZ 001101: taken if rs != 0. BEQZ 001110: taken if rs == 0.
  - Target = (branch PC+1) + imm.
- HLT 111111. Any other opcode is a NOP.
- Arithmetic is 32-bit wraparound; no overflow traps.
- R0:
  - Reads always return 0.
  - Writes to R0 are discarded, including by WB.
- Register file: written at WB edge; ID read of a register being written the same cycle returns the new value (write-through).
- Forwarding into EX operands, priority EX/MEM result over MEM/WB result over register file. Also applies to SW store data.
- Load-use: if the instruction in EX is LW and the ID instruction reads its rt, then:
  - PC and IF/ID hold for one cycle.
  - A bubble is inserted into EX.
  - Afterwards the MEM/WB forward supplies the data.
- Branch resolved in EX:
  - If taken, PC <= target next edge and the IF/ID and ID/EX contents are flushed (2-cycle penalty).
  - TAKEN_BRANCH pulses high for that cycle. No delay slot.
  - Not-taken costs nothing.
- Halt:
  - HLT decoded in ID freezes PC and feeds bubbles behind it.
  - Older instructions complete normally.
  - HALTED <= 1 when HLT reaches WB.
  - Once HALTED=1, no further Reg/Mem/PC writes occur until reset.
- Reset mid-operation clears in-flight instructions. Completed Reg/Mem writes persist.
- Simultaneous stall and taken branch: the branch wins (flush overrides stall).

Decomposition:
- Package mips32_pkg:
  - Opcode localparams.
  - Instruction-class enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP.
  - NOP instruction word.
  - Pipeline-register struct typedefs.
- One sub-module: mips32_regfile, holding Reg[], the R0 rule and write-through. Instantiate with hierarchical path such that mips.Reg resolves; if that is impossible, keep Reg in the top and skip the sub-module.

Test Plan:
- Preload Reg[k]=k for k=0..30, then run this program:
  - ADDI R1,R0,10 (0x2801000a)
  - ADDI R2,R0,20 (0x28020014)
  - ADDI R3,R0,25 (0x28030019)
  - OR R15,R7,R7 x2
  - ADD R4,R1,R2 (0x00222000)
  - OR dummy
  - ADD R5,R4,R3 (0x00832800)
  - HLT (0xfc000000)
  - Expected: R0..R5 = 0,10,20,25,30,55; halted=1 within 20 cycles.
- Same program without the dummy ORs -> identical results, proving forwarding.
- Mem[120]=85; run LW R2,0(R1) with R1=120, then ADDI R2,R2,45, then SW R2,1(R1) -> Mem[121]=130; exactly one stall cycle.
- Loop with BNEQZ, R10 counting from 3 down to 0 -> body executes 3 times. TAKEN_BRANCH pulses 2 times. Instruction after the branch executes only on fall-through.
- ADDI R0,R0,5 then ADD R1,R0,R0 -> R0=0, R1=0.
- Assert rst_n mid-program -> PC=0 and HALTED=0 immediately; Reg/Mem values already written are preserved; re-run completes correctly.
